// File: rtl/card_display_bank.sv
`default_nettype none
// ============================================================================
// card_display_bank : per-slot card registers, flash timers, registered 7-seg
// Revision 1.0
// ============================================================================
module card_display_bank #(
   parameter int  NUM_SLOTS    = 6,
   parameter int  BLINK_HALF   = 12500000,
   parameter int  FLASH_CYCLES = 50000000,
   localparam int SW           = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                   clk,
   input  logic                   resetb,
   input  logic                   load,
   input  logic [SW-1:0]          load_slot,
   input  logic [3:0]             load_card,
   input  logic                   clear_all,
   input  logic                   blink_en,
   output logic [7*NUM_SLOTS-1:0] hex_out,
   output logic                   flashing
);

   localparam int FW = (FLASH_CYCLES > 0) ? $clog2(FLASH_CYCLES + 1) : 1;
   localparam int PW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam logic [FW-1:0] c_FLASH_LOAD = FW'(FLASH_CYCLES);
   localparam logic [PW-1:0] c_PHASE_LAST = PW'(BLINK_HALF - 1);
   localparam logic [6:0]    c_BLANK      = 7'b1111111;

   function automatic logic [6:0] f_decode(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'd1:    seg = 7'b0001000;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         4'd10:   seg = 7'b1000000;
         4'd11:   seg = 7'b1100001;
         4'd12:   seg = 7'b0011000;
         4'd13:   seg = 7'b0001001;
         default: seg = c_BLANK;
      endcase
      return seg;
   endfunction

   logic [PW-1:0]        r_phase_cnt;
   logic                 r_blink_phase;
   logic                 r_flashing;
   logic [3:0]           w_card_in;
   logic [NUM_SLOTS-1:0] w_busy;

   // Codes outside 1..13 are normalised so a stored nonzero value is always a real card
   assign w_card_in = ((load_card == 4'd0) || (load_card > 4'd13)) ? 4'd0 : load_card;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_phase_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (r_phase_cnt == c_PHASE_LAST) begin
         r_phase_cnt   <= '0;
         r_blink_phase <= ~r_blink_phase;
      end else begin
         r_phase_cnt   <= r_phase_cnt + PW'(1);
      end
   end

   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic [3:0]    r_card;
      logic [FW-1:0] r_flash;
      logic [6:0]    r_hex;
      logic          w_hit;

      assign w_hit      = load && (load_slot == SW'(gi));
      assign w_busy[gi] = (r_flash != '0);

      always_ff @(posedge clk or negedge resetb) begin
         if (!resetb) begin
            r_card  <= 4'd0;
            r_flash <= '0;
         end else if (clear_all) begin
            r_card  <= 4'd0;
            r_flash <= '0;
         end else if (w_hit) begin
            r_card  <= w_card_in;
            r_flash <= c_FLASH_LOAD;
         end else if (w_busy[gi]) begin
            r_flash <= r_flash - FW'(1);
         end
      end

      always_ff @(posedge clk or negedge resetb) begin
         if (!resetb) begin
            r_hex <= c_BLANK;
         end else if (w_busy[gi] && blink_en && r_blink_phase) begin
            r_hex <= c_BLANK;
         end else begin
            r_hex <= f_decode(r_card);
         end
      end

      assign hex_out[7*gi +: 7] = r_hex;
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_flashing <= 1'b0;
      end else begin
         r_flashing <= |w_busy;
      end
   end

   assign flashing = r_flashing;

endmodule
`default_nettype wire
